// File: rtl/dc1_cache.sv
// Direct-mapped, write-through L1 data cache between the CPU load/store unit and L2.
// Zero-cycle load hits; misses fill a 128-bit tile; stores and uncached loads go to L2.
module dc1_cache #(
  parameter int unsigned LINES_LOG2 = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  regInAddr,
  input  logic [63:0]  regInData,
  input  logic         regInOE,
  input  logic         regInWR,
  input  logic [4:0]   regInOp,
  output logic [63:0]  regOutData,
  output logic [1:0]   regOutOK,
  input  logic         flush,
  output logic [31:0]  l2Addr,
  output logic [127:0] l2OutData,
  input  logic [127:0] l2InData,
  output logic         l2OE,
  output logic         l2WR,
  output logic [4:0]   l2Op,
  input  logic [1:0]   l2OK
);

  localparam int unsigned LINES = 1 << LINES_LOG2;
  localparam int unsigned TAG_W = 32 - LINES_LOG2 - 4;

  localparam logic [1:0] ST_READY = 2'b00;
  localparam logic [1:0] ST_OK    = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, BYPASS} state_t;

  state_t state, state_nx;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [127:0]      lines [LINES];

  // Request captured on leaving IDLE so the L2 transaction survives a dropped CPU request
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [4:0]  req_op;
  logic        fill_kill;

  logic                  ld, st, req_active, hit, fill_done, write_done, req_hit;
  logic [LINES_LOG2-1:0] idx, ridx;
  logic [TAG_W-1:0]      tag, rtag;
  logic [127:0]          sel_line;

  function automatic logic is_cacheable(input logic [31:0] a);
    logic [28:0] o;
    o = a[28:0];
    return (o <= 29'h0010_0000) || ((o >= 29'h0C00_0000) && (o <= 29'h1E00_0000));
  endfunction

  assign st         = regInWR & ~reset;
  assign ld         = regInOE & ~regInWR & ~reset;
  assign req_active = regInOE | regInWR;
  assign idx        = regInAddr[LINES_LOG2+3:4];
  assign tag        = regInAddr[31:LINES_LOG2+4];
  assign ridx       = req_addr[LINES_LOG2+3:4];
  assign rtag       = req_addr[31:LINES_LOG2+4];
  assign sel_line   = lines[idx];
  assign hit        = is_cacheable(regInAddr) & valid[idx] & (tags[idx] == tag) & ~flush;
  assign req_hit    = is_cacheable(req_addr) & valid[ridx] & (tags[ridx] == rtag);

  // Next state and all outputs
  always_comb begin
    state_nx   = state;
    regOutOK   = ST_READY;
    regOutData = 64'h0;
    l2OE       = 1'b0;
    l2WR       = 1'b0;
    l2Addr     = 32'h0;
    l2OutData  = 128'h0;
    l2Op       = 5'h0;
    fill_done  = 1'b0;
    write_done = 1'b0;
    case (state)
      IDLE: begin
        if (st) begin
          regOutOK = ST_HOLD;
          state_nx = WRITE;
        end else if (ld) begin
          if (!is_cacheable(regInAddr)) begin
            regOutOK = ST_HOLD;
            state_nx = BYPASS;
          end else if (hit) begin
            regOutOK = ST_OK;
            if (regInOp[1:0] == 2'b10) regOutData = {32'h0, sel_line[{regInAddr[3:2], 5'd0} +: 32]};
            else                       regOutData = sel_line[{regInAddr[3], 6'd0} +: 64];
          end else begin
            regOutOK = ST_HOLD;
            state_nx = FILL;
          end
        end
      end
      FILL: begin
        l2OE     = 1'b1;
        l2Addr   = {req_addr[31:4], 4'h0};
        regOutOK = req_active ? ST_HOLD : ST_READY;
        if (l2OK == ST_OK) begin
          fill_done = 1'b1;
          state_nx  = IDLE;
        end else if (l2OK == ST_FAULT) begin
          regOutOK = req_active ? ST_FAULT : ST_READY;
          state_nx = IDLE;
        end
      end
      WRITE: begin
        l2WR      = 1'b1;
        l2Addr    = req_addr;
        l2Op      = req_op;
        l2OutData = {64'h0, req_data};
        regOutOK  = req_active ? ST_HOLD : ST_READY;
        if (l2OK == ST_OK) begin
          regOutOK   = req_active ? ST_OK : ST_READY;
          write_done = 1'b1;
          state_nx   = IDLE;
        end else if (l2OK == ST_FAULT) begin
          regOutOK = req_active ? ST_FAULT : ST_READY;
          state_nx = IDLE;
        end
      end
      BYPASS: begin
        l2OE     = 1'b1;
        l2Addr   = req_addr;
        l2Op     = req_op;
        regOutOK = req_active ? ST_HOLD : ST_READY;
        if (l2OK == ST_OK) begin
          regOutOK   = req_active ? ST_OK : ST_READY;
          regOutData = req_active ? l2InData[63:0] : 64'h0;
          state_nx   = IDLE;
        end else if (l2OK == ST_FAULT) begin
          regOutOK = req_active ? ST_FAULT : ST_READY;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, request capture and valid bits
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= '0;
      req_addr  <= 32'h0;
      req_data  <= 64'h0;
      req_op    <= 5'h0;
      fill_kill <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        req_addr  <= regInAddr;
        req_data  <= regInData;
        req_op    <= regInOp;
        fill_kill <= 1'b0;
      end else if ((state == FILL) && flush) begin
        fill_kill <= 1'b1;
      end
      if (flush) valid <= '0;
      else if (fill_done && !fill_kill) valid[ridx] <= 1'b1;
    end
  end

  // Tag and data arrays; a write-through hit merges the stored word or half
  always_ff @(posedge clock) begin
    if (!reset && fill_done) begin
      lines[ridx] <= l2InData;
      tags[ridx]  <= rtag;
    end else if (!reset && write_done && req_hit) begin
      if (req_op[1:0] == 2'b10) lines[ridx][{req_addr[3:2], 5'd0} +: 32] <= req_data[31:0];
      else                      lines[ridx][{req_addr[3], 6'd0} +: 64]   <= req_data;
    end
  end

endmodule

// File: tb/tb_dc1_cache.sv
// Scoreboard bench for dc1_cache: directed CPU transactions push expected CPU and L2
// responses; monitors pop and compare when the DUT presents them.
module tb_dc1_cache;

  logic         clock, reset;
  logic [31:0]  regInAddr;
  logic [63:0]  regInData;
  logic         regInOE, regInWR;
  logic [4:0]   regInOp;
  logic [63:0]  regOutData;
  logic [1:0]   regOutOK;
  logic         flush;
  logic [31:0]  l2Addr;
  logic [127:0] l2OutData, l2InData;
  logic         l2OE, l2WR;
  logic [4:0]   l2Op;
  logic [1:0]   l2OK;

  dc1_cache #(.LINES_LOG2(4)) dut (
    .clock(clock), .reset(reset), .regInAddr(regInAddr), .regInData(regInData),
    .regInOE(regInOE), .regInWR(regInWR), .regInOp(regInOp), .regOutData(regOutData),
    .regOutOK(regOutOK), .flush(flush), .l2Addr(l2Addr), .l2OutData(l2OutData),
    .l2InData(l2InData), .l2OE(l2OE), .l2WR(l2WR), .l2Op(l2Op), .l2OK(l2OK)
  );

  typedef struct {
    string       name;
    logic [1:0]  ok;
    bit          chk;
    logic [63:0] data;
    int          lat;
  } resp_t;

  typedef struct {
    string        name;
    logic         oe;
    logic         wr;
    logic [31:0]  addr;
    logic [4:0]   op;
    logic [127:0] wd;
  } l2_t;

  resp_t resp_q[$];
  l2_t   l2_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, req_cycle = 0;
  int r_hold = 0, r_cnt = 0;
  logic [1:0]   r_fin  = 2'b01;
  logic [127:0] r_data = '0;
  logic         prev_strobe = 1'b0;

  localparam logic [4:0]   L32 = 5'b00010;
  localparam logic [4:0]   L64 = 5'b00011;
  localparam logic [127:0] D   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D2  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] D3  = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  // L2 responder: HOLD for r_hold cycles of a strobe, then the programmed final status
  initial begin
    l2OK = 2'b00;
    l2InData = '0;
    forever begin
      @(posedge clock);
      #2;
      if (l2OE || l2WR) begin
        if (r_cnt < r_hold) begin
          l2OK = 2'b10;
          l2InData = '0;
          r_cnt++;
        end else begin
          l2OK = r_fin;
          l2InData = r_data;
        end
      end else begin
        l2OK = 2'b00;
        l2InData = '0;
        r_cnt = 0;
      end
    end
  end

  // Monitor: CPU responses and the start of each L2 transaction
  always @(negedge clock) begin
    resp_t r;
    l2_t   e;
    if (!reset && (regOutOK == 2'b01 || regOutOK == 2'b11)) begin
      if (resp_q.size() == 0) check("resp_unexpected", {126'h0, regOutOK}, 128'h0);
      else begin
        r = resp_q.pop_front();
        check({r.name, "_ok"}, {126'h0, regOutOK}, {126'h0, r.ok});
        if (r.chk) check({r.name, "_data"}, {64'h0, regOutData}, {64'h0, r.data});
        if (r.lat >= 0) check({r.name, "_lat"}, 128'(cyc - req_cycle), 128'(r.lat));
      end
    end
    if ((l2OE || l2WR) && !prev_strobe) begin
      if (l2_q.size() == 0) check("l2_unexpected", {96'h0, l2Addr}, 128'h0);
      else begin
        e = l2_q.pop_front();
        check({e.name, "_l2strobe"}, {126'h0, l2OE, l2WR}, {126'h0, e.oe, e.wr});
        check({e.name, "_l2addr"}, {96'h0, l2Addr}, {96'h0, e.addr});
        check({e.name, "_l2op"}, {123'h0, l2Op}, {123'h0, e.op});
        check({e.name, "_l2wdata"}, l2OutData, e.wd);
      end
    end
    prev_strobe <= l2OE | l2WR;
  end

  task automatic txn(input string name, input bit wr, input logic [31:0] addr,
                     input logic [63:0] wd, input logic [4:0] op, input int hold,
                     input logic [1:0] fin, input logic [127:0] rd, input int n_l2,
                     input logic [31:0] l2a, input logic [4:0] l2op, input logic [1:0] eok,
                     input bit chk, input logic [63:0] ed, input int elat, input int flush_at);
    int    n;
    bit    done;
    l2_t   e;
    resp_t r;
    r_hold = hold;
    r_fin  = fin;
    r_data = rd;
    for (int i = 0; i < n_l2; i++) begin
      e = '{name, !wr, wr, l2a, l2op, wr ? {64'h0, wd} : 128'h0};
      l2_q.push_back(e);
    end
    r = '{name, eok, chk, ed, elat};
    resp_q.push_back(r);
    regInAddr = addr;
    regInData = wd;
    regInOp   = op;
    regInOE   = !wr;
    regInWR   = wr;
    flush     = (flush_at == 0);
    req_cycle = cyc;
    n = 0;
    done = 0;
    while (!done && n < 60) begin
      @(negedge clock);
      if (regOutOK == 2'b01 || regOutOK == 2'b11) done = 1;
      else begin
        @(posedge clock);
        #1;
        n++;
        flush = (n == flush_at);
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no OK/FAULT in %0d cycles, want one", name, n);
      resp_q.delete();
      l2_q.delete();
    end
    @(posedge clock);
    #1;
    regInOE = 1'b0;
    regInWR = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    regInAddr = '0; regInData = '0; regInOE = 1'b0; regInWR = 1'b0; regInOp = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ok", {126'h0, regOutOK}, 128'h0);
    check("rst_data", {64'h0, regOutData}, 128'h0);
    check("rst_strobes", {126'h0, l2OE, l2WR}, 128'h0);
    check("rst_l2bus", {l2Addr, l2Op, 91'h0}, 128'h0);
    check("rst_l2wdata", l2OutData, 128'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    txn("fill_miss",   0, 32'h0C000010, 64'h0, L32, 2, 2'b01, D, 1, 32'h0C000010, 5'h0, 2'b01, 1, 64'h11111111, 4, -1);
    txn("hit_w2",      0, 32'h0C000018, 64'h0, L32, 0, 2'b01, D, 0, 32'h0, 5'h0, 2'b01, 1, 64'h33333333, 0, -1);
    txn("st32",        1, 32'h0C000014, 64'h12345678_DEADBEEF, L32, 0, 2'b01, D, 1, 32'h0C000014, L32, 2'b01, 0, 64'h0, 1, -1);
    txn("hit64_lo",    0, 32'h0C000010, 64'h0, L64, 0, 2'b01, D, 0, 32'h0, 5'h0, 2'b01, 1, 64'hDEADBEEF_11111111, 0, -1);
    txn("hit64_hi",    0, 32'h0C000018, 64'h0, L64, 0, 2'b01, D, 0, 32'h0, 5'h0, 2'b01, 1, 64'h44444444_33333333, 0, -1);
    txn("hit_op00",    0, 32'h0C000018, 64'h0, 5'h0, 0, 2'b01, D, 0, 32'h0, 5'h0, 2'b01, 1, 64'h44444444_33333333, 0, -1);
    txn("st64",        1, 32'h0C000018, 64'hCAFEF00D_0BADC0DE, L64, 1, 2'b01, D, 1, 32'h0C000018, L64, 2'b01, 0, 64'h0, 2, -1);
    txn("hit_w3",      0, 32'h0C00001C, 64'h0, L32, 0, 2'b01, D, 0, 32'h0, 5'h0, 2'b01, 1, 64'hCAFEF00D, 0, -1);
    txn("conflict",    0, 32'h0C000110, 64'h0, L32, 0, 2'b01, D2, 1, 32'h0C000110, 5'h0, 2'b01, 1, 64'hA0A0A0A0, 2, -1);
    txn("refetch",     0, 32'h0C000010, 64'h0, L32, 0, 2'b01, D, 1, 32'h0C000010, 5'h0, 2'b01, 1, 64'h11111111, 2, -1);
    txn("alias",       0, 32'h8C000010, 64'h0, L32, 0, 2'b01, D3, 1, 32'h8C000010, 5'h0, 2'b01, 1, 64'hB0B0B0B0, 2, -1);
    txn("alias_back",  0, 32'h0C000010, 64'h0, L32, 0, 2'b01, D, 1, 32'h0C000010, 5'h0, 2'b01, 1, 64'h11111111, 2, -1);
    txn("bypass1",     0, 32'h1F000004, 64'h0, L32, 1, 2'b01, 128'hFFFFFFFF_EEEEEEEE_89ABCDEF_01234567, 1, 32'h1F000004, L32, 2'b01, 1, 64'h89ABCDEF_01234567, 2, -1);
    txn("bypass2",     0, 32'h1F000004, 64'h0, L32, 1, 2'b01, 128'h13572468, 1, 32'h1F000004, L32, 2'b01, 1, 64'h13572468, 2, -1);
    txn("fill_flush",  0, 32'h0C000020, 64'h0, L32, 2, 2'b01, D, 2, 32'h0C000020, 5'h0, 2'b01, 1, 64'h11111111, 8, 1);

    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;

    txn("flushed_miss", 0, 32'h0C000024, 64'h0, L32, 0, 2'b01, D, 1, 32'h0C000020, 5'h0, 2'b01, 1, 64'h22222222, 2, -1);
    txn("flush_idle",  0, 32'h0C000028, 64'h0, L32, 0, 2'b01, D, 1, 32'h0C000020, 5'h0, 2'b01, 1, 64'h33333333, 2, 0);
    txn("hit_after",   0, 32'h0C00002C, 64'h0, L32, 0, 2'b01, D, 0, 32'h0, 5'h0, 2'b01, 1, 64'h44444444, 0, -1);
    txn("fill_fault",  0, 32'h0C000030, 64'h0, L32, 1, 2'b11, D, 1, 32'h0C000030, 5'h0, 2'b11, 0, 64'h0, 2, -1);
    txn("after_fault", 0, 32'h0C000030, 64'h0, L32, 0, 2'b01, D, 1, 32'h0C000030, 5'h0, 2'b01, 1, 64'h11111111, 2, -1);

    // Reset while a store waits on L2
    begin
      l2_t e;
      r_hold = 5;
      r_fin  = 2'b01;
      e = '{"rst_write", 1'b0, 1'b1, 32'h0C000040, L32, {64'h0, 64'h55667788}};
      l2_q.push_back(e);
      regInAddr = 32'h0C000040; regInData = 64'h55667788; regInOp = L32; regInWR = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1; regInWR = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("rst_mid_l2wr", {127'h0, l2WR}, 128'h0);
      check("rst_mid_ok", {126'h0, regOutOK}, 128'h0);
      @(posedge clock); #1;
      reset = 1'b0;
    end

    repeat (4) @(posedge clock);
    check("resp_q_drained", 128'(resp_q.size()), 128'h0);
    check("l2_q_drained", 128'(l2_q.size()), 128'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
